mem_responder: RTL
==================

Name: mem_responder

Overview:
- Word-organised unified instruction/data memory target. It answers the memory requests that the multi-cycle MIPS core issues.
- Sits on the core's memory interface: address, write data and write strobe come in; read data goes out.
- Adds a req/ready handshake, configurable wait states, byte-lane writes and an error response. This lets the core be tested against slow or faulting memory.

Parameters:
- ADDR_WIDTH, 10, word-address bits; capacity is 2**ADDR_WIDTH words.
- WAIT_CYCLES, 1, extra cycles between request acceptance and response (0..15).
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to the capacity.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- req  input  1  request valid
- we  input  1  1 = write, 0 = read; sampled with req
- adr  input  32  byte address
- wdata  input  32  write data
- be  input  4  byte enables; be[i] covers wdata[8i+7:8i]
- rdata  output  32  read data, valid while ready=1 and err=0
- ready  output  1  one-cycle response strobe
- err  output  1  error flag, valid while ready=1
- dbg_addr  input  ADDR_WIDTH  debug word address
- dbg_data  output  32  combinational read of mem[dbg_addr]

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-low.
- Reset values:
  - state = IDLE, wait counter = 0.
  - ready = 0, err = 0, rdata = 0.
  - Memory contents are not reset.
- States:
  - IDLE: on req=1 at a clock edge, latch we/adr/wdata/be. Compute the offset as adr - BASE_ADDR.
    - If adr[1:0] != 0, or the offset's word index is >= 2**ADDR_WIDTH, go to ERR.
    - Otherwise, if WAIT_CYCLES == 0 go to RESP; else go to WAIT with counter = WAIT_CYCLES-1.
  - WAIT: if counter == 0 go to RESP; else decrement the counter.
  - RESP:
    - The access is performed on the edge entering RESP. A write updates only the enabled byte lanes; a read loads rdata.
    - In RESP: ready=1, err=0. Next state is IDLE.
  - ERR: ready=1, err=1. No memory write occurs and rdata holds its previous value. Next state is IDLE.
- Latency: ready rises WAIT_CYCLES+1 cycles after the edge that accepts req. Error responses rise after 1 cycle.
- Throughput: at most one transaction per WAIT_CYCLES+2 cycles. req is not sampled in WAIT, RESP or ERR.
- Handshake:
  - The requester holds req and its fields until it sees ready.
  - The latched copy is authoritative: changes to adr/wdata/we/be after acceptance are ignored.
  - Deasserting req mid-WAIT does not cancel the transaction.
- be = 4'b0000 on a write: completes normally with ready=1 and the memory is unchanged. be is ignored on reads.
- rdata holds its value outside RESP. ready and err are registered outputs.
- Reset mid-transaction: the FSM returns to IDLE immediately and ready drops. A write not yet performed is discarded; memory keeps prior contents.
- dbg_data is combinational and independent of the FSM. During the RESP cycle of a write it shows the new value.

Decomposition:
- Shared package (mem_pkg):
  - State encoding constants IDLE=2'd0, WAIT=2'd1, RESP=2'd2, ERR=2'd3.
  - Byte-lane width constant.
- Sub-module mem_array, containing:
  - 2**ADDR_WIDTH x 32 storage.
  - Synchronous write with a 4-bit byte enable.
  - One synchronous read port for the FSM.
  - One asynchronous debug read port.
- mem_responder holds the FSM, the wait counter, the request latch and the range/alignment check.

Test Plan:
- Basic read/write, WAIT_CYCLES=2, BASE_ADDR=0:
  - Write adr=0x10, wdata=0xDEADBEEF, be=4'hF.
    -> ready pulses for exactly one cycle, 3 cycles after acceptance; err=0.
  - Then read 0x10 -> rdata=0xDEADBEEF with ready; dbg_addr=4 -> dbg_data=0xDEADBEEF.
- Byte lanes:
  - Preload 0x11223344 at 0x20, then write wdata=0xAABBCCDD with be=4'b0101.
    -> A read returns 0x11BB33DD.
  - be=4'b0000 write -> ready=1, value unchanged.
- Errors:
  - Read at adr=0x22 (misaligned) -> ready=1 and err=1 one cycle after acceptance; rdata unchanged.
  - Write at adr=0x1000 with ADDR_WIDTH=10 (out of range) -> err=1 and memory unchanged.
- Zero wait / back-to-back, WAIT_CYCLES=0:
  - req held high across two writes (0x0 then 0x4).
    -> ready in cycles 1 and 3; the second request is accepted only in the IDLE cycle after RESP.
- Handshake robustness:
  - Change adr from 0x30 to 0x40 and drop req during WAIT.
    -> The write still lands at 0x30; 0x40 is untouched.
- Reset mid-op:
  - Assert rst low during WAIT of a write to 0x50 holding old value 0x12345678.
    -> ready=0 and state IDLE immediately; after release, a read of 0x50 returns 0x12345678.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the word-organised memory responder.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned NUM_LANES = 4;

endpackage

// File: rtl/mem_array.sv
// 2**ADDR_WIDTH x 32 storage: byte-lane synchronous write, synchronous FSM
// read into a holding register, and an asynchronous debug read port.
module mem_array
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  input  logic [NUM_LANES-1:0]  be,
  output logic [31:0]           rdata,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [31:0]           dbg_data
);

  logic [31:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
        if (be[i]) mem[addr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
      end
    end
  end

  // Read register only loads on an access, so it holds between responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rdata <= '0;
    else if (rd_en) rdata <= mem[addr];
  end

  assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/mem_responder.sv
// Memory target for the multi-cycle MIPS core: req/ready handshake with
// configurable wait states, byte-lane writes and error responses.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  we,
  input  logic [31:0]           adr,
  input  logic [31:0]           wdata,
  input  logic [3:0]            be,
  output logic [31:0]           rdata,
  output logic                  ready,
  output logic                  err,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [31:0]           dbg_data
);

  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t                  state;
  logic [3:0]              cnt;
  logic                    we_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [31:0]             wdata_q;
  logic [3:0]              be_q;

  logic [31:0]             offset;
  logic                    bad;
  logic                    go_resp;
  logic                    acc_we;
  logic [ADDR_WIDTH-1:0]   acc_addr;
  logic [31:0]             acc_wdata;
  logic [3:0]              acc_be;
  logic                    mem_wr;
  logic                    mem_rd;

  assign offset = adr - BASE_ADDR;
  assign bad    = (|offset[1:0]) || (|offset[31:ADDR_WIDTH+2]);

  // The access fires on the edge entering RESP; with zero wait states that
  // edge is the accepting one, so the live request fields are used instead
  // of the not-yet-loaded latch.
  assign go_resp = ((state == WAIT) && (cnt == 4'd0)) ||
                   ((state == IDLE) && req && !bad && (WAIT_CYCLES == 0));

  always_comb begin
    acc_we    = we_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    acc_be    = be_q;
    if (state == IDLE) begin
      acc_we    = we;
      acc_addr  = offset[ADDR_WIDTH+1:2];
      acc_wdata = wdata;
      acc_be    = be;
    end
  end

  assign mem_wr = go_resp && acc_we && rst;
  assign mem_rd = go_resp && !acc_we;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      ready   <= 1'b0;
      err     <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            we_q    <= we;
            addr_q  <= offset[ADDR_WIDTH+1:2];
            wdata_q <= wdata;
            be_q    <= be;
            if (bad) begin
              state <= ERR;
              ready <= 1'b1;
              err   <= 1'b1;
            end else if (WAIT_CYCLES == 0) begin
              state <= RESP;
              ready <= 1'b1;
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state <= RESP;
            ready <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  mem_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk      (clk),
    .rst_n    (rst),
    .wr_en    (mem_wr),
    .rd_en    (mem_rd),
    .addr     (acc_addr),
    .wdata    (acc_wdata),
    .be       (acc_be),
    .rdata    (rdata),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

endmodule
